// File: rtl/acc_carry_normalizer.sv
// Carry-propagate normalizer: turns redundant ACC_W-bit column sums into canonical K-bit
// digits, LS word first, then flushes the residual carry as FLUSH extra digits per frame.
module acc_carry_normalizer #(
    parameter int K     = 16,
    parameter int ACC_W = 48,
    parameter int FLUSH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_digit,
    output logic             out_last,
    output logic             ovf
);

    localparam int CW  = ACC_W - K + 1;
    localparam int FCW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam logic [FCW-1:0] LAST_CNT = FCW'(FLUSH - 1);

    if (FLUSH < 1) begin : g_bad_flush
        $error("acc_carry_normalizer: FLUSH must be at least 1");
    end

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   carry_q, carry_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [K-1:0]    digit_q, digit_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;

    logic            out_free;
    logic            accept;
    logic            flush_load;
    logic            flush_done;
    logic [ACC_W:0]  word_sum;

    // The output register can take a new digit when empty or being drained this cycle.
    assign out_free   = !out_valid_q || out_ready;
    assign accept     = in_valid && (state_q == ST_RUN) && out_free;
    assign flush_load = (state_q == ST_FLUSH) && out_free;
    assign flush_done = flush_load && (flush_cnt_q == LAST_CNT);
    // One bit wider than the accumulator so a full word plus maximum carry cannot overflow.
    assign word_sum   = {1'b0, in_acc} + {{K{1'b0}}, carry_q};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves state_d unassigned
        // (which would otherwise infer a latch).
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_done)        state_d = ST_RUN;
            default:                         state_d = ST_RUN;
        endcase
    end

    always_comb begin
        carry_d     = carry_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        digit_d     = digit_q;
        last_d      = last_q;
        ovf_d       = ovf_q;

        if (accept) begin
            out_valid_d = 1'b1;
            digit_d     = word_sum[K-1:0];
            last_d      = 1'b0;
            ovf_d       = 1'b0;
            carry_d     = word_sum[ACC_W:K];
            if (in_last) flush_cnt_d = '0;
        end else if (flush_load) begin
            out_valid_d = 1'b1;
            digit_d     = carry_q[K-1:0];
            last_d      = 1'b0;
            ovf_d       = 1'b0;
            carry_d     = carry_q >> K;
            flush_cnt_d = flush_cnt_q + FCW'(1);
            if (flush_done) begin
                // Anything still above the emitted digits is lost precision: flag it and
                // leave the carry clean for the next frame.
                last_d      = 1'b1;
                ovf_d       = (carry_q >> K) != '0;
                carry_d     = '0;
                flush_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q     <= '0;
            flush_cnt_q <= '0;
            out_valid_q <= 1'b0;
            digit_q     <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            carry_q     <= carry_d;
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= out_valid_d;
            digit_q     <= digit_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_RUN) && out_free;
        out_valid = out_valid_q;
        out_digit = digit_q;
        out_last  = last_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_acc_carry_normalizer.sv
// Bench for acc_carry_normalizer: directed cases plus random frames scored against a
// big-integer model (frame value split into K-bit digits).
module tb_acc_carry_normalizer;

    localparam int K     = 16;
    localparam int ACC_W = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_last;
    logic [ACC_W-1:0] in_acc;
    logic             out_valid, out_ready, out_last, ovf;
    logic [K-1:0]     out_digit;

    logic             v1, rdy1, l1, ov1_valid, ov1_last, ov1_ovf;
    logic [ACC_W-1:0] a1;
    logic [K-1:0]     ov1_digit;

    acc_carry_normalizer #(.K(K), .ACC_W(ACC_W), .FLUSH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_last(out_last), .ovf(ovf)
    );

    acc_carry_normalizer #(.K(K), .ACC_W(ACC_W), .FLUSH(1)) u_dut_f1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1), .in_acc(a1), .in_last(l1),
        .out_valid(ov1_valid), .out_ready(1'b1), .out_digit(ov1_digit),
        .out_last(ov1_last), .ovf(ov1_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [K-1:0] digit;
        logic         last;
        logic         ovf;
    } exp_t;

    exp_t             exp_q[$];
    logic [ACC_W-1:0] frame_w[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               hs = 0;
    bit               rand_ready = 1'b0;
    bit               gaps = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the frame is one integer sum(w[i] * 2^(K*i)); digits are its K-bit
    // slices and ovf says whether anything remains above the last emitted digit.
    function automatic void model_frame(input int flush);
        logic [255:0] total;
        int           n;
        exp_t         e;
        total = '0;
        n = frame_w.size();
        for (int i = 0; i < n; i++)
            total = total + ({208'd0, frame_w[i]} << (K * i));
        for (int d = 0; d < n + flush; d++) begin
            e.digit = total[K*d +: K];
            e.last  = (d == n + flush - 1);
            e.ovf   = e.last && ((total >> (K * (n + flush))) != '0);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_word(input logic [ACC_W-1:0] w, input logic last);
        int waited;
        in_acc   = w;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame();
        int n;
        model_frame(2);
        n = frame_w.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(frame_w[i], i == n - 1);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [ACC_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return r[ACC_W-1:0];
        endcase
    endfunction

    // Scoreboard / protocol monitor, sampling mid-cycle.
    initial begin
        bit              prev_stall = 1'b0;
        logic [K+1:0]    prev_payload = '0;
        exp_t            e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_payload", {out_digit, out_last, ovf}, prev_payload);
                end
                if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
                if (out_valid && out_ready) begin
                    hs++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_digit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("digit", out_digit, e.digit);
                        check("last", out_last, e.last);
                        check("ovf", ovf, e.ovf);
                    end
                end
                prev_stall   = out_valid && !out_ready;
                prev_payload = {out_digit, out_last, ovf};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0, c0, c1, n;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_acc = '0; out_ready = 1'b0;
        v1 = 1'b0; l1 = 1'b0; a1 = '0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_digit", out_digit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Single word, with one-cycle latency check.
        frame_w = '{48'h0000_0001_2345};
        model_frame(2);
        send_word(48'h0000_0001_2345, 1'b1);
        check("latency_valid", out_valid, 1);
        check("latency_digit", out_digit, 16'h2345);
        wait_drain("drain_single");

        // Carry chain through all flush digits.
        frame_w = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001};
        send_frame();
        wait_drain("drain_chain");

        // Same chain on the FLUSH=1 instance: residual carry must raise ovf.
        check("f1_in_ready", rdy1, 1);
        v1 = 1'b1; a1 = 48'hFFFF_FFFF_FFFF; l1 = 1'b0;
        @(posedge clk);
        #1;
        a1 = 48'h0000_0000_0001; l1 = 1'b1;
        @(negedge clk);
        check("f1_d0", {ov1_valid, ov1_digit, ov1_last, ov1_ovf}, {1'b1, 16'hFFFF, 2'b00});
        @(posedge clk);
        #1;
        v1 = 1'b0; l1 = 1'b0;
        @(negedge clk);
        check("f1_d1", {ov1_valid, ov1_digit, ov1_last, ov1_ovf}, {1'b1, 16'h0000, 2'b00});
        @(negedge clk);
        check("f1_d2", {ov1_valid, ov1_digit, ov1_last, ov1_ovf}, {1'b1, 16'h0000, 2'b11});
        @(negedge clk);
        check("f1_idle", ov1_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for 5 cycles mid-frame.
        frame_w = '{48'h1111_2222_3333, 48'hFFFF_0000_FFFF, 48'h8000_8000_8000, 48'h0000_0000_0042};
        fork
            send_frame();
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // Back-to-back frames with out_ready high: one digit every cycle.
        fork
            begin
                frame_w = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0001};
                send_frame();
                frame_w = '{48'h0000_0000_0001, 48'h0000_0000_0002, 48'h0000_0000_0003};
                send_frame();
            end
            begin
                hs0 = hs;
                n = 0;
                do begin
                    @(negedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 100);
                c0 = cyc;
                n = 0;
                while (hs - hs0 < 10 && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                c1 = cyc;
                check("b2b_digits", hs - hs0, 10);
                check("b2b_cycles", c1 - c0, 9);
            end
        join
        wait_drain("drain_b2b");

        // Reset while stuck in FLUSH.
        out_ready = 1'b0;
        frame_w = '{48'h1234_5678_9ABC};
        send_frame();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        frame_w = '{48'h0000_0000_0007};
        send_frame();
        wait_drain("drain_after_reset");

        // Random frames under random backpressure and input gaps.
        rand_ready = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 30; f++) begin
            frame_w.delete();
            repeat ($urandom_range(1, 8)) frame_w.push_back(rand_word());
            send_frame();
        end
        wait_drain("drain_random");
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
